// File: rtl/pc_call_sequencer.sv
// Program-counter sequencer and call/return controller for the PIC16C57 core.
// Drives the 2-level return stack and inserts the one-cycle flush after taken events.
module pc_call_sequencer #(
    parameter int              PC_W      = 11,
    parameter logic [PC_W-1:0] RST_VEC   = {PC_W{1'b1}},
    parameter int              STK_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            op_valid,
    input  logic [2:0]      op,
    input  logic [8:0]      k_in,
    input  logic [7:0]      pcl_data,
    input  logic [1:0]      pa_in,
    input  logic [PC_W-1:0] stk_top,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      stk_cmd,
    output logic [PC_W-1:0] stk_data,
    output logic            flush,
    output logic [1:0]      depth,
    output logic            stk_ovf,
    output logic            stk_unf
);

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_PUSH = 2'd1;
    localparam logic [1:0] CMD_POP  = 2'd2;

    localparam logic [2:0] OP_GOTO   = 3'd1;
    localparam logic [2:0] OP_CALL   = 3'd2;
    localparam logic [2:0] OP_RETLW  = 3'd3;
    localparam logic [2:0] OP_SKIP   = 3'd4;
    localparam logic [2:0] OP_PCL_WR = 3'd5;

    localparam logic [1:0] DEPTH_MAX = 2'(STK_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] goto_tgt;
    logic [PC_W-1:0] call_tgt;
    logic [PC_W-1:0] pcl_tgt;
    logic            op_live;

    assign pc_inc   = pc + PC_W'(1);
    assign goto_tgt = PC_W'({pa_in, k_in});
    assign call_tgt = PC_W'({pa_in, 1'b0, k_in[7:0]});
    assign pcl_tgt  = PC_W'({pa_in, 1'b0, pcl_data});
    assign stk_data = pc;

    // An op is only acted upon in RUN, out of reset and not stalled.
    assign op_live = rst && !stall && op_valid && (state == ST_RUN);

    always_comb begin
        stk_cmd = CMD_NOP;
        if (op_live) begin
            case (op)
                OP_CALL:  stk_cmd = CMD_PUSH;
                OP_RETLW: stk_cmd = CMD_POP;
                default:  stk_cmd = CMD_NOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_RUN;
            pc      <= RST_VEC;
            flush   <= 1'b0;
            depth   <= 2'd0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (!stall) begin
            if (state == ST_FLUSH) begin
                pc    <= pc_inc;
                state <= ST_RUN;
                flush <= 1'b0;
            end else begin
                pc    <= pc_inc;
                state <= ST_RUN;
                flush <= 1'b0;
                if (op_valid) begin
                    case (op)
                        OP_GOTO: begin
                            pc    <= goto_tgt;
                            state <= ST_FLUSH;
                            flush <= 1'b1;
                        end
                        OP_CALL: begin
                            pc    <= call_tgt;
                            state <= ST_FLUSH;
                            flush <= 1'b1;
                        end
                        OP_RETLW: begin
                            pc    <= stk_top;
                            state <= ST_FLUSH;
                            flush <= 1'b1;
                        end
                        OP_SKIP: begin
                            state <= ST_FLUSH;
                            flush <= 1'b1;
                        end
                        OP_PCL_WR: begin
                            pc    <= pcl_tgt;
                            state <= ST_FLUSH;
                            flush <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            // Depth saturates at both ends; the stack itself still sees the command.
            if (stk_cmd == CMD_PUSH) begin
                if (depth == DEPTH_MAX) stk_ovf <= 1'b1;
                else                    depth   <= depth + 2'd1;
            end else if (stk_cmd == CMD_POP) begin
                if (depth == 2'd0) stk_unf <= 1'b1;
                else               depth   <= depth - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_call_sequencer.sv
// Directed bench for pc_call_sequencer: a reference model pushes expected state into
// a scoreboard each cycle, popped and compared after the clock edge.
module tb_pc_call_sequencer;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] PUSH = 2'd1;
    localparam logic [1:0] POP  = 2'd2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        op_valid;
    logic [2:0]  op;
    logic [8:0]  k_in;
    logic [7:0]  pcl_data;
    logic [1:0]  pa_in;
    logic [10:0] stk_top;
    logic [10:0] pc;
    logic [1:0]  stk_cmd;
    logic [10:0] stk_data;
    logic        flush;
    logic [1:0]  depth;
    logic        stk_ovf;
    logic        stk_unf;

    pc_call_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .op_valid (op_valid),
        .op       (op),
        .k_in     (k_in),
        .pcl_data (pcl_data),
        .pa_in    (pa_in),
        .stk_top  (stk_top),
        .pc       (pc),
        .stk_cmd  (stk_cmd),
        .stk_data (stk_data),
        .flush    (flush),
        .depth    (depth),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] pc;
        logic        flush;
        logic [1:0]  depth;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [10:0] m_pc;
    logic        m_flush;
    logic [1:0]  m_depth;
    logic        m_ovf;
    logic        m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic [2:0] o,
                        input logic [8:0] k, input logic [7:0] pd, input logic [1:0] pa,
                        input logic [10:0] top);
        logic [1:0] e_cmd;
        exp_t       e;
        exp_t       got;
        rst = r; stall = s; op_valid = v; op = o;
        k_in = k; pcl_data = pd; pa_in = pa; stk_top = top;
        #1;
        e_cmd = NOP;
        if (r && !s && v && !m_flush) begin
            if (o == 3'd2) e_cmd = PUSH;
            if (o == 3'd3) e_cmd = POP;
        end
        chk("stk_cmd", {30'd0, stk_cmd}, {30'd0, e_cmd});
        if (e_cmd == PUSH) chk("stk_data", {21'd0, stk_data}, {21'd0, m_pc});

        if (!r) begin
            m_pc = 11'h7FF; m_flush = 1'b0; m_depth = 2'd0; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (!s) begin
            if (m_flush) begin
                m_pc = m_pc + 11'd1;
                m_flush = 1'b0;
            end else begin
                m_pc = m_pc + 11'd1;
                if (v) begin
                    case (o)
                        3'd1: begin m_pc = {pa, k};              m_flush = 1'b1; end
                        3'd2: begin m_pc = {pa, 1'b0, k[7:0]};   m_flush = 1'b1; end
                        3'd3: begin m_pc = top;                  m_flush = 1'b1; end
                        3'd4: begin                              m_flush = 1'b1; end
                        3'd5: begin m_pc = {pa, 1'b0, pd};       m_flush = 1'b1; end
                        default: ;
                    endcase
                end
            end
            if (e_cmd == PUSH) begin
                if (m_depth == 2'd2) m_ovf = 1'b1;
                else                 m_depth = m_depth + 2'd1;
            end else if (e_cmd == POP) begin
                if (m_depth == 2'd0) m_unf = 1'b1;
                else                 m_depth = m_depth - 2'd1;
            end
        end
        e.pc = m_pc; e.flush = m_flush; e.depth = m_depth; e.ovf = m_ovf; e.unf = m_unf;
        sb.push_back(e);

        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("pc",    {21'd0, pc},    {21'd0, got.pc});
            chk("flush", {31'd0, flush}, {31'd0, got.flush});
            chk("depth", {30'd0, depth}, {30'd0, got.depth});
            chk("ovf",   {31'd0, stk_ovf}, {31'd0, got.ovf});
            chk("unf",   {31'd0, stk_unf}, {31'd0, got.unf});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 8'd0, 2'd0, 11'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [8:0] k, input logic [7:0] pd,
                         input logic [1:0] pa, input logic [10:0] top);
        step(1'b1, 1'b0, 1'b1, o, k, pd, pa, top);
    endtask

    task automatic do_rst();
        step(1'b0, 1'b0, 1'b0, 3'd0, 9'd0, 8'd0, 2'd0, 11'd0);
    endtask

    initial begin
        m_pc = 11'h7FF; m_flush = 1'b0; m_depth = 2'd0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset for two clocks, then wrap from 0x7FF to 0x000.
        do_rst();
        do_rst();
        chk("rst_pc", {21'd0, pc}, 32'h7FF);
        chk("rst_depth", {30'd0, depth}, 32'd0);
        idle(1);
        chk("wrap_pc", {21'd0, pc}, 32'h000);

        // GOTO from 0x010 with page 01.
        idle(16);
        chk("pc_at_10", {21'd0, pc}, 32'h010);
        do_op(3'd1, 9'h1A5, 8'h00, 2'b01, 11'h000);
        chk("goto_pc", {21'd0, pc}, 32'h3A5);
        chk("goto_flush", {31'd0, flush}, 32'd1);
        idle(1);
        chk("goto_pc_next", {21'd0, pc}, 32'h3A6);
        chk("goto_flush_done", {31'd0, flush}, 32'd0);

        // CALL from 0x123, then RETLW back.
        do_op(3'd1, 9'h122, 8'h00, 2'b00, 11'h000);
        idle(1);
        chk("pc_at_123", {21'd0, pc}, 32'h123);
        do_op(3'd2, 9'h140, 8'h00, 2'b00, 11'h000);
        chk("call_pc", {21'd0, pc}, 32'h040);
        chk("call_depth", {30'd0, depth}, 32'd1);
        idle(2);
        do_op(3'd3, 9'h000, 8'h00, 2'b00, 11'h123);
        chk("ret_pc", {21'd0, pc}, 32'h123);
        chk("ret_depth", {30'd0, depth}, 32'd0);
        idle(1);

        // Three nested CALLs: depth 1,2,2 with overflow on the third.
        do_op(3'd2, 9'h110, 8'h00, 2'b10, 11'h000);
        idle(1);
        do_op(3'd2, 9'h020, 8'h00, 2'b11, 11'h000);
        idle(1);
        do_op(3'd2, 9'h030, 8'h00, 2'b01, 11'h000);
        chk("nest_depth", {30'd0, depth}, 32'd2);
        chk("nest_ovf", {31'd0, stk_ovf}, 32'd1);
        chk("nest_unf", {31'd0, stk_unf}, 32'd0);
        idle(1);

        // RETLW at depth 0 after reset: underflow is sticky until reset.
        do_rst();
        chk("ovf_cleared", {31'd0, stk_ovf}, 32'd0);
        do_op(3'd3, 9'h000, 8'h00, 2'b00, 11'h055);
        chk("unf_pc", {21'd0, pc}, 32'h055);
        chk("unf_flag", {31'd0, stk_unf}, 32'd1);
        idle(3);
        chk("unf_hold", {31'd0, stk_unf}, 32'd1);

        // SKIP, PCL write, reserved op.
        do_op(3'd4, 9'h000, 8'h00, 2'b00, 11'h000);
        idle(1);
        do_op(3'd5, 9'h000, 8'hC3, 2'b10, 11'h000);
        chk("pcl_pc", {21'd0, pc}, 32'h4C3);
        idle(1);
        do_op(3'd6, 9'h1FF, 8'hFF, 2'b11, 11'h7FF);
        do_op(3'd7, 9'h1FF, 8'hFF, 2'b11, 11'h7FF);

        // Stall for three clocks inside FLUSH with a live CALL presented.
        do_op(3'd1, 9'h0F0, 8'h00, 2'b00, 11'h000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 3'd2, 9'h011, 8'h00, 2'b00, 11'h000);
        chk("stall_pc", {21'd0, pc}, 32'h0F0);
        chk("stall_flush", {31'd0, flush}, 32'd1);
        do_op(3'd2, 9'h011, 8'h00, 2'b00, 11'h000);
        chk("post_stall_pc", {21'd0, pc}, 32'h0F1);
        chk("post_stall_flush", {31'd0, flush}, 32'd0);
        idle(2);

        // Reset asserted while stalled in FLUSH.
        do_op(3'd1, 9'h077, 8'h00, 2'b01, 11'h000);
        step(1'b1, 1'b1, 1'b0, 3'd0, 9'd0, 8'd0, 2'd0, 11'd0);
        step(1'b0, 1'b1, 1'b1, 3'd2, 9'd0, 8'd0, 2'd0, 11'd0);
        chk("rst_stall_flush", {31'd0, flush}, 32'd0);
        chk("rst_stall_unf", {31'd0, stk_unf}, 32'd0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
